// File: rtl/reg_bus_master_pkg.sv
// Shared register-bus definitions: default widths, frame opcodes, response codes
// and the command/bus FSM state encoding.
package reg_bus_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

endpackage

// File: rtl/reg_bus_master_if.sv
// On-chip register bus: single master drives request fields, register file answers
// with ready and read data.
interface reg_bus_master_if #(
  parameter int ADDR_W = reg_bus_pkg::ADDR_W_DEF,
  parameter int DATA_W = reg_bus_pkg::DATA_W_DEF
);
  logic              val;
  logic [ADDR_W-1:0] addr;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output val, addr, write, wdata, input rdata, ready);
  modport slave  (input val, addr, write, wdata, output rdata, ready);
endinterface

// File: rtl/reg_bus_master_resp_ser.sv
// Response serializer: holds a 1- or 5-byte response and emits it over a
// valid/ready byte stream, first byte then read data MSB first.
module reg_bus_resp_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  load_first,
  input  logic        load_long,
  input  logic [31:0] load_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done
);
  logic [31:0] data_q;
  logic [2:0]  idx;
  logic        long_q;

  assign done = tx_valid && tx_ready && (idx == (long_q ? 3'd4 : 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      data_q   <= '0;
      idx      <= '0;
      long_q   <= 1'b0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_first;
      idx      <= '0;
      long_q   <= load_long;
      // Only a read completion captures bus data; other responses leave it untouched.
      if (load_long) data_q <= load_data;
    end else if (tx_valid && tx_ready) begin
      if (done) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= data_q[31:24];
        data_q  <= {data_q[23:0], 8'h00};
        idx     <= idx + 3'd1;
      end
    end
  end
endmodule

// File: rtl/reg_bus_master.sv
// Register bus master: decodes framed byte commands from the host link, runs one
// bus transaction per frame and returns an acknowledge or read-data response.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BUS_TIMEOUT = 255,
  parameter int RX_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  reg_bus_master_if.master bus
);
  localparam int TW  = $clog2(BUS_TIMEOUT + 1);
  localparam int RXW = $clog2(RX_TIMEOUT + 1);

  state_t            state, state_nx;
  logic              is_write;
  logic [7:0]        addr_hi;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        byte_cnt;
  logic [RXW-1:0]    rx_cnt;
  logic [TW-1:0]     wait_cnt;
  logic              val_q;

  logic       rx_fire, rx_tmo, in_frame, bus_ok, bus_tmo;
  logic       ser_load, ser_long, ser_done;
  logic [7:0] ser_first;

  assign rx_fire  = rx_valid && rx_ready;
  assign in_frame = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_DATA);
  assign rx_tmo   = in_frame && (rx_cnt == RXW'(RX_TIMEOUT - 1));
  // A ready sampled on the timeout cycle completes normally.
  assign bus_ok   = val_q && bus.ready;
  assign bus_tmo  = val_q && !bus.ready && (wait_cnt == TW'(BUS_TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    ser_load  = 1'b0;
    ser_long  = 1'b0;
    ser_first = RSP_OK;
    unique case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_nx = S_ADDR_HI;
          end else begin
            state_nx  = S_RESP;
            ser_load  = 1'b1;
            ser_first = RSP_ERR;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_fire)     state_nx = S_ADDR_LO;
        else if (rx_tmo) state_nx = S_IDLE;
      end
      S_ADDR_LO: begin
        if (rx_fire)     state_nx = is_write ? S_DATA : S_BUS;
        else if (rx_tmo) state_nx = S_IDLE;
      end
      S_DATA: begin
        if (rx_fire) begin
          if (byte_cnt == 2'd3) state_nx = S_BUS;
        end else if (rx_tmo) begin
          state_nx = S_IDLE;
        end
      end
      S_BUS: begin
        if (bus_ok) begin
          state_nx = S_RESP;
          ser_load = 1'b1;
          ser_long = !is_write;
        end else if (bus_tmo) begin
          state_nx  = S_RESP;
          ser_load  = 1'b1;
          ser_first = RSP_TMO;
        end
      end
      S_RESP: begin
        if (ser_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      is_write <= 1'b0;
      addr_hi  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byte_cnt <= '0;
      rx_cnt   <= '0;
      wait_cnt <= '0;
      val_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      // Registered so it stays low through reset and drops on the edge entering BUS.
      rx_ready <= (state_nx == S_IDLE) || (state_nx == S_ADDR_HI) ||
                  (state_nx == S_ADDR_LO) || (state_nx == S_DATA);
      if (state == S_IDLE && rx_fire)    is_write <= (rx_data == OP_WR);
      if (state == S_ADDR_HI && rx_fire) addr_hi  <= rx_data;
      if (state == S_ADDR_LO && rx_fire) addr_q   <= ADDR_W'({addr_hi, rx_data});
      if (state == S_DATA && rx_fire) begin
        wdata_q  <= {wdata_q[DATA_W-9:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end else if (state != S_DATA) begin
        byte_cnt <= '0;
      end
      if (rx_fire || !in_frame || state_nx != state) rx_cnt <= '0;
      else                                           rx_cnt <= rx_cnt + 1'b1;
      val_q    <= (state == S_BUS) && (state_nx == S_BUS);
      wait_cnt <= (val_q && state_nx == S_BUS) ? wait_cnt + 1'b1 : '0;
    end
  end

  assign bus.val   = val_q;
  assign bus.addr  = addr_q;
  assign bus.write = is_write;
  assign bus.wdata = wdata_q;

  reg_bus_resp_ser u_resp_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_first (ser_first),
    .load_long  (ser_long),
    .load_data  (bus.rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .done       (ser_done)
  );
endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: write, read, bad opcode, bus timeout,
// tx backpressure, rx frame timeout and reset with a live bus request.
module tb_reg_bus_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  int         total = 0;
  int         bad   = 0;

  reg_bus_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  reg_bus_master #(
    .ADDR_W      (10),
    .DATA_W      (32),
    .BUS_TIMEOUT (8),
    .RX_TIMEOUT  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk(64'(g < 100), 64'd1, "rx_accept_bound");
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input string tag);
    int g = 0;
    tx_ready = 1'b1;
    while (!tx_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tx_valid, tx_data}, {1'b1, b}, tag);
    @(negedge clk);
  endtask

  // Plays the register file: ready is held high during high-cycle number ready_at
  // (0 = never). Checks latency, val width and stable request fields.
  task automatic bus_txn(input logic [31:0] rd, input int ready_at, input int exp_hi,
                         input logic [9:0] exp_addr, input logic exp_write,
                         input logic [31:0] exp_wdata, input string tag);
    int lat = 0;
    int hi  = 0;
    logic [9:0]  ca;
    logic        cw;
    logic [31:0] cd;
    logic        stable = 1'b1;
    while (!bus.val && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    ca = bus.addr;
    cw = bus.write;
    cd = bus.wdata;
    while (bus.val && hi < 1000) begin
      hi++;
      if (bus.addr !== ca || bus.write !== cw || bus.wdata !== cd) stable = 1'b0;
      bus.ready = (hi == ready_at);
      bus.rdata = (hi == ready_at) ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    bus.ready = 1'b0;
    chk(64'(lat), 64'd1, {tag, "_latency"});
    chk(64'(hi), 64'(exp_hi), {tag, "_val_cycles"});
    chk(64'(ca), 64'(exp_addr), {tag, "_addr"});
    chk(64'(cw), 64'(exp_write), {tag, "_write"});
    if (exp_write) chk(64'(cd), 64'(exp_wdata), {tag, "_wdata"});
    chk(64'(stable), 64'd1, {tag, "_stable"});
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    bus.ready = 1'b0; bus.rdata = '0;
    repeat (3) @(negedge clk);
    chk({rx_ready, tx_valid, tx_data, bus.val, bus.write}, '0, "reset_ctrl");
    chk({bus.addr, bus.wdata}, '0, "reset_bus");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk(64'(rx_ready), 64'd1, "idle_rx_ready");

    // Write 0x00AA1234 to 0x200, ready one cycle after val
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34);
    chk({bus.val, rx_ready}, '0, "wr_after_last_byte");
    bus_txn(32'h0, 2, 2, 10'h200, 1'b1, 32'h00AA1234, "wr");
    expect_tx(8'h4B, "wr_ack");
    chk(64'(tx_valid), 64'd0, "wr_resp_end");

    // Read 0x104
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h04);
    bus_txn(32'h00050003, 1, 1, 10'h104, 1'b0, 32'h0, "rd");
    expect_tx(8'h4B, "rd_b0"); expect_tx(8'h00, "rd_b1"); expect_tx(8'h05, "rd_b2");
    expect_tx(8'h00, "rd_b3"); expect_tx(8'h03, "rd_b4");
    chk(64'(tx_valid), 64'd0, "rd_resp_end");

    // Bad opcode, then a read with upper address bits set (0xFF10 -> 0x310)
    send_byte(8'h41);
    chk(64'(bus.val), 64'd0, "bad_no_val");
    expect_tx(8'h45, "bad_err");
    chk({tx_valid, bus.val}, '0, "bad_end");
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'h10);
    bus_txn(32'hCAFEF00D, 3, 3, 10'h310, 1'b0, 32'h0, "rd2");
    expect_tx(8'h4B, "rd2_b0"); expect_tx(8'hCA, "rd2_b1"); expect_tx(8'hFE, "rd2_b2");
    expect_tx(8'hF0, "rd2_b3"); expect_tx(8'h0D, "rd2_b4");

    // Bus timeout with ready never asserted, then ready on the 8th cycle
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus_txn(32'h0, 0, 8, 10'h005, 1'b1, 32'h11223344, "tmo");
    expect_tx(8'h54, "tmo_rsp");
    chk(64'(tx_valid), 64'd0, "tmo_resp_end");
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h07);
    bus_txn(32'h01020304, 8, 8, 10'h007, 1'b0, 32'h0, "edge");
    expect_tx(8'h4B, "edge_b0"); expect_tx(8'h01, "edge_b1"); expect_tx(8'h02, "edge_b2");
    expect_tx(8'h03, "edge_b3"); expect_tx(8'h04, "edge_b4");

    // Backpressure mid read response
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    bus_txn(32'hA1B2C3D4, 1, 1, 10'h020, 1'b0, 32'h0, "bp");
    expect_tx(8'h4B, "bp_b0"); expect_tx(8'hA1, "bp_b1");
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk({tx_valid, tx_data}, {1'b1, 8'hB2}, "bp_hold");
    end
    expect_tx(8'hB2, "bp_b2"); expect_tx(8'hC3, "bp_b3"); expect_tx(8'hD4, "bp_b4");
    chk(64'(tx_valid), 64'd0, "bp_end");

    // RX timeout: 15 idle cycles keep the frame, 16 discard it
    send_byte(8'h57); send_byte(8'h02);
    repeat (15) @(negedge clk);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    bus_txn(32'h0, 1, 1, 10'h200, 1'b1, 32'h00000001, "rx15");
    expect_tx(8'h4B, "rx15_ack");
    send_byte(8'h57); send_byte(8'h02);
    for (int i = 0; i < 16; i++) begin
      chk({bus.val, tx_valid}, '0, "rx16_quiet");
      @(negedge clk);
    end
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h04);
    bus_txn(32'h00000055, 1, 1, 10'h104, 1'b0, 32'h0, "rx16");
    expect_tx(8'h4B, "rx16_b0"); expect_tx(8'h00, "rx16_b1"); expect_tx(8'h00, "rx16_b2");
    expect_tx(8'h00, "rx16_b3"); expect_tx(8'h55, "rx16_b4");

    // Reset while val is high
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h23);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h09);
    begin
      int g = 0;
      while (!bus.val && g < 50) begin
        @(negedge clk);
        g++;
      end
      chk(64'(bus.val), 64'd1, "rst_val_seen");
    end
    rst = 1'b1;
    @(negedge clk);
    chk({bus.val, tx_valid, rx_ready, bus.write}, '0, "rst_mid_ctrl");
    chk({bus.addr, bus.wdata, tx_data}, '0, "rst_mid_bus");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk({rx_ready, bus.val, tx_valid}, {1'b1, 1'b0, 1'b0}, "rst_release");
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    bus_txn(32'h0000BEEF, 2, 2, 10'h001, 1'b0, 32'h0, "post");
    expect_tx(8'h4B, "post_b0"); expect_tx(8'h00, "post_b1"); expect_tx(8'h00, "post_b2");
    expect_tx(8'hBE, "post_b3"); expect_tx(8'hEF, "post_b4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
